dac_stream_arbiter: RTL and testbench

Round-robin scheduler that shares the single DAC AXI4-Stream output between several pulse-engine sample sources. It sits between the pulse engines and the DAC-facing AXI master and grants the stream to one source for a whole burst, delimited by `tlast`. It registers the output beat and enforces a maximum burst length so that no source can starve the others.

---
 rtl/dac_arb_pkg.sv | 17 +
 rtl/dac_stream_arbiter_rr_pick.sv | 29 ++
 rtl/dac_stream_arbiter.sv | 128 ++++++++++++
 tb/tb_dac_stream_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_arb_pkg.sv
// Shared types and constants for the DAC stream arbiter.
// Optional starvation counter: DAC_ARB_UNDERFLOW_CNT_EN.
package dac_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } dac_arb_state_e;

  localparam int UNDERFLOW_W = 16;

  localparam int IQ_I_HI = 31;
  localparam int IQ_I_LO = 16;
  localparam int IQ_Q_HI = 15;
  localparam int IQ_Q_LO = 0;

endpackage

// File: rtl/dac_stream_arbiter_rr_pick.sv
// Round-robin selector: first requester strictly after the last
// grant, wrapping modulo N. Purely combinational.
module dac_rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          found,
  output logic [IW-1:0] idx
);

  int          j;
  logic [IW-1:0] jj;

  // Walk offsets high to low so the nearest requester wins.
  always_comb begin
    found = |req;
    idx   = last;
    j     = 0;
    jj    = '0;
    for (int k = N; k >= 1; k--) begin
      j  = (int'(last) + k) % N;
      jj = IW'(j);
      if (req[jj]) idx = jj;
    end
  end

endmodule

// File: rtl/dac_stream_arbiter.sv
// Burst round-robin arbiter sharing one DAC AXI4-Stream output.
// Define DAC_ARB_UNDERFLOW_CNT_EN to add the underflow_cnt port.
module dac_stream_arbiter
  import dac_arb_pkg::*;
#(
  parameter int NUM_SRC   = 4,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 256
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC*DATA_W-1:0] s_tdata,
  input  logic [NUM_SRC-1:0]        s_tvalid,
  input  logic [NUM_SRC-1:0]        s_tlast,
  output logic [NUM_SRC-1:0]        s_tready,
  output logic [DATA_W-1:0]         m_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      m_axis_tlast,
  output logic [$clog2(NUM_SRC)-1:0] grant_id,
`ifdef DAC_ARB_UNDERFLOW_CNT_EN
  output logic [UNDERFLOW_W-1:0]    underflow_cnt,
`endif
  output logic                      busy
);

  localparam int IW = $clog2(NUM_SRC);
  localparam int CW = $clog2(MAX_BURST + 1);

  dac_arb_state_e state, state_nxt;

  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_inc;
  logic              pick_found;
  logic [IW-1:0]     pick_idx;
  logic              out_free;
  logic              acc;
  logic              beat_end;
  logic              sel_valid;
  logic              sel_last;
  logic [DATA_W-1:0] sel_data;

  dac_rr_pick #(
    .N  (NUM_SRC),
    .IW (IW)
  ) u_pick (
    .req   (s_tvalid),
    .last  (grant_id),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign sel_valid = s_tvalid[grant_id];
  assign sel_last  = s_tlast[grant_id];
  assign sel_data  =
    s_tdata[int'(grant_id)*DATA_W +: DATA_W];

  // Output slot can take a beat when empty or draining.
  assign out_free = !m_axis_tvalid || m_axis_tready;
  assign cnt_inc  = cnt + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    s_tready  = '0;
    acc       = 1'b0;
    beat_end  = 1'b0;
    busy      = 1'b0;
    unique case (state)
      IDLE: begin
        if (pick_found) state_nxt = BURST;
      end
      BURST: begin
        busy               = 1'b1;
        s_tready[grant_id] = out_free;
        acc                = sel_valid && out_free;
        beat_end           = acc && (sel_last ||
                             cnt_inc == CW'(MAX_BURST));
        if (beat_end) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_id <= IW'(NUM_SRC - 1);
      cnt      <= '0;
    end else if (state == IDLE && pick_found) begin
      grant_id <= pick_idx;
      cnt      <= '0;
    end else if (acc) begin
      cnt <= cnt_inc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else if (acc) begin
      m_axis_tdata  <= sel_data;
      m_axis_tvalid <= 1'b1;
      m_axis_tlast  <= beat_end;
    end else if (m_axis_tvalid && m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end
  end

`ifdef DAC_ARB_UNDERFLOW_CNT_EN
  // Starvation: granted source silent while the DAC could take data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underflow_cnt <= '0;
    end else if (state == BURST && !sel_valid &&
                 out_free && underflow_cnt != '1) begin
      underflow_cnt <= underflow_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dac_stream_arbiter.sv
// Directed table-driven bench for dac_stream_arbiter
// (NUM_SRC=4, DATA_W=32, MAX_BURST=4).
module tb_dac_stream_arbiter;

  localparam int NS = 4;
  localparam int DW = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic [NS*DW-1:0] s_tdata;
  logic [NS-1:0]  s_tvalid;
  logic [NS-1:0]  s_tlast;
  logic [NS-1:0]  s_tready;
  logic [DW-1:0]  m_axis_tdata;
  logic           m_axis_tvalid;
  logic           m_axis_tready;
  logic           m_axis_tlast;
  logic [1:0]     grant_id;
  logic           busy;
`ifdef DAC_ARB_UNDERFLOW_CNT_EN
  logic [15:0]    underflow_cnt;
`endif

  dac_stream_arbiter #(
    .NUM_SRC   (NS),
    .DATA_W    (DW),
    .MAX_BURST (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_tdata       (s_tdata),
    .s_tvalid      (s_tvalid),
    .s_tlast       (s_tlast),
    .s_tready      (s_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .grant_id      (grant_id),
`ifdef DAC_ARB_UNDERFLOW_CNT_EN
    .underflow_cnt (underflow_cnt),
`endif
    .busy          (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          src;
    logic [31:0] data;
    logic        last;
    logic        exp_last;
    int          exp_gid;
  } vec_t;

  vec_t        tbl[16];
  int          ntbl;

  logic [31:0] bdata[NS][16];
  logic        blast[NS][16];
  int          blen[NS];
  int          bptr[NS];

  logic [31:0] odata[64];
  logic        olast[64];
  int          ogid[64];
  int          ostamp[64];
  int          ocnt;

  int          cyc;
  int          st_lo, st_len;
  int          gp_lo, gp_len;
  logic [31:0] prev_d;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic clear_src();
    for (int i = 0; i < NS; i++) begin
      blen[i] = 0;
      bptr[i] = 0;
    end
    ocnt   = 0;
    cyc    = 0;
    st_lo  = 0;
    st_len = 0;
    gp_lo  = 0;
    gp_len = 0;
  endtask

  task automatic load_tbl();
    int s;
    for (int k = 0; k < ntbl; k++) begin
      s = tbl[k].src;
      bdata[s][blen[s]] = tbl[k].data;
      blast[s][blen[s]] = tbl[k].last;
      blen[s]++;
    end
  endtask

  task automatic drive();
    logic gap;
    gap = (cyc >= gp_lo) && (cyc < gp_lo + gp_len);
    for (int i = 0; i < NS; i++) begin
      if (bptr[i] < blen[i] && !gap) begin
        s_tvalid[i]         = 1'b1;
        s_tdata[i*DW +: DW] = bdata[i][bptr[i]];
        s_tlast[i]          = blast[i][bptr[i]];
      end else begin
        s_tvalid[i]         = 1'b0;
        s_tdata[i*DW +: DW] = '0;
        s_tlast[i]          = 1'b0;
      end
    end
    m_axis_tready =
      !((cyc >= st_lo) && (cyc < st_lo + st_len));
  endtask

  task automatic run(input int budget);
    logic [NS-1:0] acc;
    int extra;
    extra = 0;
    cyc   = 0;
    drive();
    while (cyc < budget && extra < 4) begin
      @(negedge clk);
      acc = s_tvalid & s_tready;
      chk("ready_onehot",
          32'($countones(s_tready) <= 1), 32'd1);
      if (cyc >= st_lo && cyc < st_lo + st_len) begin
        chk("stall_ready", 32'(s_tready), 32'd0);
        if (cyc > st_lo)
          chk("stall_data", m_axis_tdata, prev_d);
      end
      prev_d = m_axis_tdata;
      if (m_axis_tvalid && m_axis_tready && ocnt < 64) begin
        odata[ocnt]  = m_axis_tdata;
        olast[ocnt]  = m_axis_tlast;
        ogid[ocnt]   = int'(grant_id);
        ostamp[ocnt] = cyc;
        ocnt++;
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < NS; i++)
        if (acc[i]) bptr[i]++;
      cyc++;
      drive();
      if (ocnt >= ntbl) extra++;
    end
    if (ocnt < ntbl) begin
      tests++;
      fails++;
      $display("FAIL timeout: got %0d beats expected %0d",
               ocnt, ntbl);
    end
    for (int k = 0; k < ntbl && k < ocnt; k++) begin
      chk("out_data", odata[k], tbl[k].data);
      chk("out_last", 32'(olast[k]), 32'(tbl[k].exp_last));
      chk("out_gid", ogid[k], tbl[k].exp_gid);
    end
    chk("beat_count", ocnt, ntbl);
    chk("idle_after", 32'(busy), 32'd0);
  endtask

  function automatic vec_t mk(input int s,
                              input logic [31:0] d,
                              input logic l,
                              input logic el);
    vec_t v;
    v.src      = s;
    v.data     = d;
    v.last     = l;
    v.exp_last = el;
    v.exp_gid  = s;
    return v;
  endfunction

  initial begin
    rst           = 1'b1;
    s_tdata       = '0;
    s_tvalid      = '0;
    s_tlast       = '0;
    m_axis_tready = 1'b1;
    clear_src();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_tlast", 32'(m_axis_tlast), 32'd0);
    chk("rst_tdata", m_axis_tdata, 32'd0);
    chk("rst_tready", 32'(s_tready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_gid", 32'(grant_id), 32'd3);
`ifdef DAC_ARB_UNDERFLOW_CNT_EN
    chk("rst_uflow", 32'(underflow_cnt), 32'd0);
`endif
    @(posedge clk);
    #1 rst = 1'b0;

    // Contention: all four request 2-beat bursts.
    clear_src();
    ntbl = 8;
    for (int s = 0; s < NS; s++) begin
      tbl[2*s]   = mk(s, 32'hC0 + 32'(2*s), 1'b0, 1'b0);
      tbl[2*s+1] = mk(s, 32'hC1 + 32'(2*s), 1'b1, 1'b1);
    end
    load_tbl();
    run(100);
    for (int k = 1; k < 8; k++)
      chk("rr_gap", ostamp[k] - ostamp[k-1],
          (k % 2 == 1) ? 32'd1 : 32'd2);

    // Single source, 4 beats.
    clear_src();
    ntbl = 4;
    for (int k = 0; k < 4; k++)
      tbl[k] = mk(0, 32'hA0 + 32'(k), k == 3, k == 3);
    load_tbl();
    run(100);
    chk("latency", ostamp[0], 32'd2);

    // Backpressure on src3 mid-burst.
    clear_src();
    ntbl   = 4;
    st_lo  = 3;
    st_len = 5;
    for (int k = 0; k < 4; k++)
      tbl[k] = mk(3, 32'hB0 + 32'(k), k == 3, k == 3);
    load_tbl();
    run(100);

    // 6-beat pulse on src1 split at MAX_BURST=4.
    clear_src();
    ntbl = 6;
    for (int k = 0; k < 6; k++)
      tbl[k] = mk(1, 32'hD0 + 32'(k), k == 5,
                  k == 3 || k == 5);
    load_tbl();
    run(100);
    chk("split_gap", ostamp[4] - ostamp[3], 32'd2);

    // Reset while src2 is mid-burst.
    clear_src();
    ntbl = 4;
    for (int k = 0; k < 4; k++)
      tbl[k] = mk(2, 32'hE0 + 32'(k), k == 3, k == 3);
    load_tbl();
    drive();
    repeat (2) @(posedge clk);
    #1;
    chk("pre_rst_gid", 32'(grant_id), 32'd2);
    chk("pre_rst_vld", 32'(m_axis_tvalid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("arst_tdata", m_axis_tdata, 32'd0);
    chk("arst_tlast", 32'(m_axis_tlast), 32'd0);
    chk("arst_tready", 32'(s_tready), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_gid", 32'(grant_id), 32'd3);
    clear_src();
    drive();
    @(posedge clk);
    #1 rst = 1'b0;
    ntbl   = 2;
    tbl[0] = mk(0, 32'h11, 1'b1, 1'b1);
    tbl[1] = mk(2, 32'h22, 1'b1, 1'b1);
    load_tbl();
    run(100);

    // Granted source goes silent for 3 cycles mid-burst.
    clear_src();
    ntbl   = 4;
    gp_lo  = 3;
    gp_len = 3;
    for (int k = 0; k < 4; k++)
      tbl[k] = mk(0, 32'hF0 + 32'(k), k == 3, k == 3);
    load_tbl();
    run(100);
    chk("gap_bubble", ostamp[2] - ostamp[1], 32'd4);
`ifdef DAC_ARB_UNDERFLOW_CNT_EN
    chk("uflow_cnt", 32'(underflow_cnt), 32'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
